// File: rtl/debounce_toggle.sv
// Synchronises and debounces a raw button, emitting a clean level, one-cycle rise/fall pulses, a toggle bit and a press count.
// Latency: an input change held from edge E0 is accepted at edge E0+STABLE_CYCLES+2.
// Backpressure: none; the input is a free-running level and every output is a registered level or pulse.
module debounce_toggle #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16,
    parameter int PRESS_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_in,
    output logic               btn_level,
    output logic               rise_pulse,
    output logic               fall_pulse,
    output logic               toggle_q,
    output logic [PRESS_W-1:0] press_count
);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            state       <= IDLE_LOW;
            cnt         <= '0;
            btn_level   <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            toggle_q    <= 1'b0;
            press_count <= '0;
        end else begin
            sync1      <= btn_in;
            sync2      <= sync1;
            // Pulses default low so they last exactly one cycle after acceptance.
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;

            case (state)
                IDLE_LOW: begin
                    if (sync2) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= IDLE_HIGH;
                        btn_level   <= 1'b1;
                        rise_pulse  <= 1'b1;
                        toggle_q    <= ~toggle_q;
                        press_count <= press_count + PRESS_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!sync2) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync2) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= IDLE_LOW;
                        btn_level  <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_toggle.sv
// Scenario bench for debounce_toggle: tasks push expected pulses into a scoreboard, a negedge monitor pops and checks them.
module tb_debounce_toggle;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_in;
    logic       btn_level;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       toggle_q;
    logic [7:0] press_count;

    typedef struct {
        bit         rise;
        bit         tog;
        logic [7:0] cnt;
        int         at;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         n_rise = 0;
    int         n_fall = 0;
    bit         exp_tog = 1'b0;
    logic [7:0] exp_cnt = 8'd0;

    debounce_toggle #(.STABLE_CYCLES(4), .CNT_W(16), .PRESS_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .toggle_q   (toggle_q),
        .press_count(press_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the next scoreboard entry in kind, state and timing.
    always @(negedge clk) begin
        if (rise_pulse || fall_pulse) begin
            vectors++;
            if (rise_pulse && fall_pulse) begin
                miscompares++;
                $display("FAIL both_pulses: rise=%0b fall=%0b, required not both high (cyc %0d)", rise_pulse, fall_pulse, cyc);
            end
            if (rise_pulse) n_rise++;
            if (fall_pulse) n_fall++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: rise=%0b fall=%0b at cyc %0d, none expected", rise_pulse, fall_pulse, cyc);
            end else begin
                mon_e = sbq.pop_front();
                vectors++;
                if (rise_pulse !== mon_e.rise || btn_level !== mon_e.rise) begin
                    miscompares++;
                    $display("FAIL pulse_kind: rise=%0b level=%0b, required rise=%0b level=%0b", rise_pulse, btn_level, mon_e.rise, mon_e.rise);
                end
                vectors++;
                if (cyc !== mon_e.at) begin
                    miscompares++;
                    $display("FAIL pulse_time: got cyc %0d, required cyc %0d", cyc, mon_e.at);
                end
                vectors++;
                if (toggle_q !== mon_e.tog || press_count !== mon_e.cnt) begin
                    miscompares++;
                    $display("FAIL pulse_state: toggle=%0b count=%0d, required toggle=%0b count=%0d", toggle_q, press_count, mon_e.tog, mon_e.cnt);
                end
            end
        end
    end

    // Stimulus helper only: drives a clean level change and records the pulse it must cause.
    task automatic drive_edge(input bit v, input int hold);
        exp_t e;
        if (v) begin
            exp_tog = ~exp_tog;
            exp_cnt = exp_cnt + 8'd1;
        end
        e.rise = v;
        e.tog  = exp_tog;
        e.cnt  = exp_cnt;
        e.at   = cyc + 1 + 6;
        sbq.push_back(e);
        btn_in = v;
        repeat (hold) @(negedge clk);
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        btn_in = 1'b0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        exp_tog = 1'b0;
        exp_cnt = 8'd0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        btn_in = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({btn_level, rise_pulse, fall_pulse, toggle_q, press_count} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, required all zero", {btn_level, rise_pulse, fall_pulse, toggle_q, press_count});
        end
        btn_in = 1'b0;
        reset  = 1'b0;
        repeat (8) @(negedge clk);
        vectors++;
        if ({btn_level, toggle_q, press_count} !== 10'd0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b, required all zero", {btn_level, toggle_q, press_count});
        end
    endtask

    task automatic test_first_press();
        int t0;
        bit after;
        t0 = cyc + 1;
        drive_edge(1'b1, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            after = (cyc >= t0 + 6);
            vectors++;
            if (btn_level !== after || toggle_q !== after || press_count !== {7'd0, after}) begin
                miscompares++;
                $display("FAIL first_press_cyc%0d: level=%0b toggle=%0b count=%0d, required %0b %0b %0d",
                         cyc, btn_level, toggle_q, press_count, after, after, after);
            end
        end
        vectors++;
        if (sbq.size() !== 0) begin
            miscompares++;
            $display("FAIL first_press_missing: %0d pulses outstanding, required 0", sbq.size());
        end
    endtask

    task automatic test_release();
        drive_edge(1'b0, 10);
        vectors++;
        if (btn_level !== 1'b0 || toggle_q !== 1'b1 || press_count !== 8'd1 || sbq.size() !== 0) begin
            miscompares++;
            $display("FAIL release: level=%0b toggle=%0b count=%0d pending=%0d, required 0 1 1 0",
                     btn_level, toggle_q, press_count, sbq.size());
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            btn_in = 1'b1;
            repeat (3) @(negedge clk);
            btn_in = 1'b0;
            @(negedge clk);
            btn_in = 1'b1;
            repeat (3) @(negedge clk);
            btn_in = 1'b0;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (btn_level !== 1'b0 || press_count !== 8'd0 || toggle_q !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce: level=%0b count=%0d toggle=%0b, required 0 0 0", btn_level, press_count, toggle_q);
        end
    endtask

    task automatic test_three_presses();
        int r0;
        int f0;
        apply_reset();
        r0 = n_rise;
        f0 = n_fall;
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b1, 10);
            drive_edge(1'b0, 10);
        end
        vectors++;
        if (n_rise - r0 !== 3 || n_fall - f0 !== 3) begin
            miscompares++;
            $display("FAIL three_presses_pulses: rises=%0d falls=%0d, required 3 3", n_rise - r0, n_fall - f0);
        end
        vectors++;
        if (toggle_q !== 1'b1 || press_count !== 8'd3) begin
            miscompares++;
            $display("FAIL three_presses_end: toggle=%0b count=%0d, required 1 3", toggle_q, press_count);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            drive_edge(1'b1, 8);
            drive_edge(1'b0, 8);
        end
        vectors++;
        if (press_count !== 8'd0 || toggle_q !== 1'b0 || sbq.size() !== 0) begin
            miscompares++;
            $display("FAIL wrap: count=%0d toggle=%0b pending=%0d, required 0 0 0", press_count, toggle_q, sbq.size());
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        btn_in = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({btn_level, rise_pulse, fall_pulse, toggle_q, press_count} !== 12'd0) begin
                miscompares++;
                $display("FAIL mid_wait_reset: got %b, required all zero", {btn_level, rise_pulse, fall_pulse, toggle_q, press_count});
            end
        end
        reset = 1'b0;
        drive_edge(1'b1, 10);
        vectors++;
        if (press_count !== 8'd1 || btn_level !== 1'b1 || sbq.size() !== 0) begin
            miscompares++;
            $display("FAIL requalify: count=%0d level=%0b pending=%0d, required 1 1 0", press_count, btn_level, sbq.size());
        end
    endtask

    task automatic test_reset_collision();
        apply_reset();
        btn_in = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({btn_level, rise_pulse, toggle_q, press_count} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_collision: got %b, required all zero", {btn_level, rise_pulse, toggle_q, press_count});
        end
        btn_in = 1'b0;
        reset  = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (press_count !== 8'd0 || toggle_q !== 1'b0) begin
            miscompares++;
            $display("FAIL after_collision: count=%0d toggle=%0b, required 0 0", press_count, toggle_q);
        end
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_press();
        test_release();
        test_bounce();
        test_three_presses();
        test_wrap();
        test_reset_mid_wait();
        test_reset_collision();
        vectors++;
        if (sbq.size() !== 0) begin
            miscompares++;
            $display("FAIL final_scoreboard: %0d pulses never seen, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
